// File: rtl/pwm_pkg.sv
// pwm_pkg: shared constants, types and helpers for the multi-channel PWM block.
//   PWM_CH_DEFAULT / PWM_RES_DEFAULT : default channel count and resolution
//   pwm_max(res)                     : largest counter/duty code for a resolution
//   cnt_dir_t                        : counter direction, used only when
//                                      PWM_CENTER_ALIGN_EN is defined
package pwm_pkg;

    localparam int unsigned PWM_CH_DEFAULT  = 4;
    localparam int unsigned PWM_RES_DEFAULT = 4;

    function automatic int unsigned pwm_max(input int unsigned res);
        return (32'd1 << res) - 32'd1;
    endfunction

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } cnt_dir_t;

endpackage

// File: rtl/pwm_multi_channel_if.sv
// pwm_multi_channel_if: duty/enable inputs and PWM status outputs of the block.
//   duty_in      : packed duty values, channel k at [k*RES +: RES]
//   duty_wr      : one-cycle strobe capturing duty_in into the shadow registers
//   ch_en        : per-channel output enable
//   pwm_out      : registered PWM outputs
//   clk_div      : registered 50 % clock, one period per PWM period
//   period_start : one-cycle pulse at the first phase of each period
//   upd_pending  : shadow holds a value not yet transferred to active
// master = the controller driving duties, slave = the PWM block.
interface pwm_multi_channel_if
    import pwm_pkg::*;
#(
    parameter int unsigned CH  = PWM_CH_DEFAULT,
    parameter int unsigned RES = PWM_RES_DEFAULT
) ();

    logic [CH*RES-1:0] duty_in;
    logic              duty_wr;
    logic [CH-1:0]     ch_en;
    logic [CH-1:0]     pwm_out;
    logic              clk_div;
    logic              period_start;
    logic              upd_pending;

    modport master (
        output duty_in, duty_wr, ch_en,
        input  pwm_out, clk_div, period_start, upd_pending
    );

    modport slave (
        input  duty_in, duty_wr, ch_en,
        output pwm_out, clk_div, period_start, upd_pending
    );

endinterface

// File: rtl/pwm_channel_cmp.sv
// pwm_channel_cmp: one PWM channel - shadow/active duty registers and the
// registered compare against the shared period counter.
//   clk_3125KHz, rst_n : clock, asynchronous active-low reset
//   cnt                : shared period counter
//   duty_in, duty_wr   : duty value for this channel and its write strobe
//   boundary           : high on the period's last cycle (transfer point)
//   ch_en              : output enable
//   pwm_out            : registered PWM output
module pwm_channel_cmp
    import pwm_pkg::*;
#(
    parameter int unsigned RES = PWM_RES_DEFAULT
) (
    input  logic           clk_3125KHz,
    input  logic           rst_n,
    input  logic [RES-1:0] cnt,
    input  logic [RES-1:0] duty_in,
    input  logic           duty_wr,
    input  logic           boundary,
    input  logic           ch_en,
    output logic           pwm_out
);

    logic [RES-1:0] shadow;
    logic [RES-1:0] active;

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            pwm_out <= 1'b0;
        end else begin
            if (duty_wr)
                shadow <= duty_in;
            // A write on the boundary cycle bypasses the shadow so it still
            // lands in the next period.
            if (boundary)
                active <= duty_wr ? duty_in : shadow;
            pwm_out <= ch_en && (cnt < active);
        end
    end

endmodule

// File: rtl/pwm_multi_channel.sv
// pwm_multi_channel: CH-channel PWM generator on a shared period counter.
//   clk_3125KHz : system clock
//   rst_n       : asynchronous active-low reset
//   bus         : pwm_multi_channel_if.slave (duty_in, duty_wr, ch_en in;
//                 pwm_out, clk_div, period_start, upd_pending out)
// Define PWM_CENTER_ALIGN_EN for center-aligned counting (0..MAX..1, period
// 2*MAX); otherwise the counter is edge-aligned (0..MAX, period 2^RES).
module pwm_multi_channel
    import pwm_pkg::*;
#(
    parameter int unsigned CH  = PWM_CH_DEFAULT,
    parameter int unsigned RES = PWM_RES_DEFAULT
) (
    input logic             clk_3125KHz,
    input logic             rst_n,
    pwm_multi_channel_if.slave bus
);

    localparam logic [RES-1:0] CNT_MAX = RES'(pwm_max(RES));

    logic [RES-1:0] cnt;
    logic           boundary;
    logic           div_next;
    logic           clk_div_q;
    logic           period_start_q;
    logic           upd_pending_q;
    logic [CH-1:0]  pwm_q;

`ifdef PWM_CENTER_ALIGN_EN
    cnt_dir_t dir;

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dir <= DIR_UP;
        end else if (dir == DIR_UP) begin
            if (cnt == CNT_MAX) begin
                cnt <= CNT_MAX - RES'(1);
                dir <= DIR_DOWN;
            end else begin
                cnt <= cnt + RES'(1);
            end
        end else begin
            if (cnt == RES'(1)) begin
                cnt <= '0;
                dir <= DIR_UP;
            end else begin
                cnt <= cnt - RES'(1);
            end
        end
    end

    assign boundary = (dir == DIR_DOWN) && (cnt == RES'(1));
    assign div_next = (dir == DIR_UP) && (cnt != CNT_MAX);
`else
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= cnt + RES'(1);
    end

    assign boundary = (cnt == CNT_MAX);
    // cnt < 2^(RES-1) is exactly the MSB being clear.
    assign div_next = ~cnt[RES-1];
`endif

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            clk_div_q      <= 1'b0;
            period_start_q <= 1'b0;
            upd_pending_q  <= 1'b0;
        end else begin
            clk_div_q      <= div_next;
            period_start_q <= (cnt == '0);
            if (boundary)
                upd_pending_q <= 1'b0;
            else if (bus.duty_wr)
                upd_pending_q <= 1'b1;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_ch
        pwm_channel_cmp #(.RES(RES)) u_ch (
            .clk_3125KHz (clk_3125KHz),
            .rst_n       (rst_n),
            .cnt         (cnt),
            .duty_in     (bus.duty_in[k*RES +: RES]),
            .duty_wr     (bus.duty_wr),
            .boundary    (boundary),
            .ch_en       (bus.ch_en[k]),
            .pwm_out     (pwm_q[k])
        );
    end

    assign bus.pwm_out      = pwm_q;
    assign bus.clk_div      = clk_div_q;
    assign bus.period_start = period_start_q;
    assign bus.upd_pending  = upd_pending_q;

endmodule

// File: tb/tb_pwm_multi_channel.sv
// tb_pwm_multi_channel: directed bench for pwm_multi_channel (CH=4, RES=4,
// edge-aligned). A phase-based model predicts every output each cycle; a few
// literal expectations (pulse counts per period, reset values) pin the model.
module tb_pwm_multi_channel;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int errors = 0;
    int checks = 0;

    pwm_multi_channel_if #(.CH(4), .RES(4)) bus ();

    pwm_multi_channel #(.CH(4), .RES(4)) dut (
        .clk_3125KHz (clk),
        .rst_n       (rst_n),
        .bus         (bus)
    );

    always #160 clk = ~clk;

    initial begin
        #(320 * 5000);
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the period is 16 phases; m_phase is the counter value during the
    // current cycle. Outputs after an edge describe the phase before it.
    int          m_phase = 0;
    logic [3:0]  m_active [4] = '{default: '0};
    logic [3:0]  m_shadow [4] = '{default: '0};
    logic        m_pend   = 1'b0;
    logic [3:0]  exp_pwm  = '0;
    logic        exp_div  = 1'b0;
    logic        exp_ps   = 1'b0;
    logic        exp_pend = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  = 0;
            m_active = '{default: '0};
            m_shadow = '{default: '0};
            m_pend   = 1'b0;
            exp_pwm  = '0;
            exp_div  = 1'b0;
            exp_ps   = 1'b0;
            exp_pend = 1'b0;
        end else begin
            for (int k = 0; k < 4; k++)
                exp_pwm[k] = bus.ch_en[k] && (m_phase < int'(m_active[k]));
            exp_div = (m_phase < 8);
            exp_ps  = (m_phase == 0);
            if (bus.duty_wr) begin
                for (int k = 0; k < 4; k++)
                    m_shadow[k] = bus.duty_in[k*4 +: 4];
                m_pend = 1'b1;
            end
            if (m_phase == 15) begin
                for (int k = 0; k < 4; k++)
                    m_active[k] = m_shadow[k];
                m_pend = 1'b0;
            end
            exp_pend = m_pend;
            m_phase  = (m_phase + 1) % 16;
        end
    end

    always @(negedge clk) begin
        check("pwm_out",      32'(bus.pwm_out),      32'(exp_pwm));
        check("clk_div",      32'(bus.clk_div),      32'(exp_div));
        check("period_start", 32'(bus.period_start), 32'(exp_ps));
        check("upd_pending",  32'(bus.upd_pending),  32'(exp_pend));
    end

    task automatic wait_phase(input int p);
        int n = 0;
        while (m_phase != p && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            checks++;
            errors++;
            $display("FAIL wait_phase: got timeout required phase %0d", p);
        end
    endtask

    task automatic write_duty(input logic [15:0] v);
        bus.duty_in = v;
        bus.duty_wr = 1'b1;
        @(negedge clk);
        bus.duty_wr = 1'b0;
    endtask

    // Counts high cycles over one 16-cycle window starting at the current negedge.
    task automatic measure(output int hi [4], output int ps, output int dv);
        hi = '{default: 0};
        ps = 0;
        dv = 0;
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < 4; k++)
                hi[k] += int'(bus.pwm_out[k]);
            ps += int'(bus.period_start);
            dv += int'(bus.clk_div);
            @(negedge clk);
        end
    endtask

    int hi [4];
    int ps, dv, ps_tot, hi_tot;

    initial begin
        bus.duty_in = '0;
        bus.duty_wr = 1'b0;
        bus.ch_en   = 4'hF;

        #1;
        check("reset pwm_out",      32'(bus.pwm_out),      32'h0);
        check("reset clk_div",      32'(bus.clk_div),      32'h0);
        check("reset period_start", 32'(bus.period_start), 32'h0);
        check("reset upd_pending",  32'(bus.upd_pending),  32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // All duties 4.
        wait_phase(3);
        write_duty(16'h4444);
        check("pending after write", 32'(bus.upd_pending), 32'h1);
        wait_phase(1);
        measure(hi, ps, dv);
        for (int k = 0; k < 4; k++) check("duty4 high count", 32'(hi[k]), 32'd4);
        check("period_start per period", 32'(ps), 32'd1);
        check("clk_div high per period", 32'(dv), 32'd8);

        // ch0 = 0, ch1 = 15.
        write_duty(16'h44F0);
        wait_phase(1);
        measure(hi, ps, dv);
        check("duty0 high count",  32'(hi[0]), 32'd0);
        check("duty15 high count", 32'(hi[1]), 32'd15);

        // 2 at cnt=5, then 9 at cnt=10: last write wins.
        wait_phase(5);
        write_duty(16'h2222);
        wait_phase(10);
        write_duty(16'h9999);
        check("pending mid period", 32'(bus.upd_pending), 32'h1);
        wait_phase(15);
        check("pending before boundary", 32'(bus.upd_pending), 32'h1);
        wait_phase(1);
        measure(hi, ps, dv);
        for (int k = 0; k < 4; k++) check("last write wins", 32'(hi[k]), 32'd9);

        // Write exactly on the boundary cycle.
        wait_phase(15);
        write_duty(16'h6666);
        check("pending after boundary write", 32'(bus.upd_pending), 32'h0);
        wait_phase(1);
        measure(hi, ps, dv);
        for (int k = 0; k < 4; k++) check("boundary write duty", 32'(hi[k]), 32'd6);

        // ch_en[2] dropped at cnt=1, restored at cnt=3, duty 8.
        write_duty(16'h8888);
        wait_phase(1);
        bus.ch_en = 4'b1011;
        @(negedge clk);
        check("ch2 disabled", 32'(bus.pwm_out), 32'hB);
        wait_phase(3);
        bus.ch_en = 4'hF;
        @(negedge clk);
        check("ch2 re-enabled", 32'(bus.pwm_out), 32'hF);

        // Reset at cnt=9.
        wait_phase(9);
        #40 rst_n = 1'b0;
        #1;
        check("async reset pwm_out",     32'(bus.pwm_out),      32'h0);
        check("async reset clk_div",     32'(bus.clk_div),      32'h0);
        check("async reset upd_pending", 32'(bus.upd_pending),  32'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("restart period_start", 32'(bus.period_start), 32'h1);
        ps_tot = 1;
        hi_tot = 0;
        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            hi_tot += int'(bus.pwm_out != 4'h0);
            ps_tot += int'(bus.period_start);
        end
        check("post-reset pwm stays low", 32'(hi_tot), 32'd0);
        check("post-reset period_start count", 32'(ps_tot), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_multi_channel.md
# pwm_multi_channel

Parametrised multi-channel PWM generator: a successor to the single-channel 4-bit PWM block. A shared period counter drives CH independent duty comparators. Duty values pass through shadow registers that update only at a period boundary, so there are no glitched periods. The block sits beside the motor and LED drivers on the 3.125 MHz domain and also provides a 50 % divided clock and a period-start strobe for downstream samplers.

## Interface
- CH, 4, number of PWM channels (1..16)
- RES, 4, counter/duty resolution in bits (2..12); MAX = 2^RES-1
- clk_3125KHz  input  1  system clock; single clock domain
- rst_n  input  1  asynchronous, active-low reset
- duty_in  input  CH*RES  packed duty values; channel k at [k*RES +: RES]
- duty_wr  input  1  one-cycle strobe; captures duty_in into the shadow registers
- ch_en  input  CH  per-channel output enable
- pwm_out  output  CH  registered PWM outputs
- clk_div  output  1  registered 50 % clock, one period per PWM period
- period_start  output  1  one-cycle pulse at the first phase of each period
- upd_pending  output  1  high while shadow holds a value not yet transferred to active

## Operation
- Reset values: cnt=0, active[k]=0, shadow[k]=0, pwm_out=0, clk_div=0, period_start=0, upd_pending=0.
- Counter:
  - Edge-aligned (default): cnt runs 0,1,…,MAX and wraps to 0.
  - Period length = 2^RES cycles (16 for RES=4).
- Compare:
  - next pwm_out[k] = ch_en[k] && (cnt < active[k]).
  - Duty 0 gives constant low.
  - Duty MAX gives high for MAX of 2^RES cycles. There is no full-on code.
- clk_div: next value = 1 when cnt < 2^(RES-1), else 0.
- period_start: next value = 1 when cnt == 0.
- Shadow update:
  - duty_wr copies duty_in into all shadow[k] and sets upd_pending.
  - A second duty_wr before the transfer overwrites shadow; last write wins.
- Transfer:
  - On the boundary cycle, active[k] <= shadow[k] and upd_pending clears.
  - The boundary cycle is cnt == MAX (edge mode).
  - The new duty takes effect from the compare at cnt == 0.
- Simultaneous duty_wr on the boundary cycle:
  - duty_in goes directly into both active and shadow.
  - upd_pending ends the cycle at 0.
- ch_en:
  - Deassertion forces pwm_out[k] low on the next edge.
  - The counter and duty transfer continue unaffected.
  - Reassertion resumes mid-period at the current compare result.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). After release, counting restarts at 0; active duty is 0 until the first transfer.

## Timing
- All outputs are registered. Each output reflects the cnt value of the previous cycle, so there is 1 cycle of latency from cnt to pins.
- period_start and clk_div rise on the same edge, aligned with the first cycle of pwm_out for phase 0.
- Duty-write-to-effect latency:
  - Minimum 1 cycle, when the write lands on the boundary cycle.
  - Maximum 2^RES cycles (edge mode) before the first affected output phase.
- No handshake backpressure: duty_wr is always accepted.

## Configuration
- PWM_CENTER_ALIGN_EN, when defined, selects center-aligned mode:
  - cnt counts 0→MAX up, then MAX-1→1 down; period = 2*MAX cycles (30 for RES=4).
  - Compare is unchanged (cnt < active), giving a symmetric pulse centred on cnt=0.
  - clk_div is high while counting up (cnt 0..MAX-1 on the up-slope) and low otherwise.
  - Boundary cycle = cnt == 1 while counting down.
- Without the macro, the block is edge-aligned exactly as in Operation, and no direction register is synthesised.

## Structure
- Shared package pwm_pkg holds:
  - the default RES/CH constants;
  - a function computing MAX from RES;
  - the enum cnt_dir_t {DIR_UP, DIR_DOWN}, used only under the macro.
- One sub-module, pwm_channel_cmp:
  - holds the shadow/active registers and registered compare for one channel;
  - generated CH times.
- The counter, clk_div and period_start logic live in the top module.

## Test plan
- Reset, then duty_wr once with all duties = 4, RES=4: after the first boundary, each pwm_out is high for 4 of 16 cycles; period_start pulses every 16 cycles; clk_div is 8 high / 8 low.
- Duties 0 and 15 on ch0/ch1: ch0 stays low; ch1 is low exactly 1 cycle per 16-cycle period.
- Write duty 2 mid-period (cnt=5), then duty 9 at cnt=10:
  - upd_pending stays high until the boundary;
  - the next period shows 9, never 2.
- duty_wr landing exactly on cnt == MAX with value 6: the following period uses 6 and upd_pending is 0 after that edge.
- Drop ch_en[2] at cnt=1 with duty 8: pwm_out[2] goes low on the next edge while the other channels are unaffected; re-enable at cnt=3 and pwm_out[2] returns high for phases 3..7.
- Assert rst_n low at cnt=9, hold 3 cycles, release: all outputs are 0 at once; counting restarts at 0; outputs stay low until a new duty is written.
